// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command checker.
//   cmd_e        : decoded SDRAM command
//   init_state_e : power-up sequence tracker state
//   *_BIT        : bit positions inside command_bus
//                  {cke, cs_n, cas_n, ras_n, we_n, (reserved), dqm[1:0]}
//   PC133_*      : timing defaults for a PC133 part at 133 MHz
package sdram_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5,
        LMR = 3'd6,
        BST = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_POWERUP  = 2'd0,
        ST_WAIT_PRE = 2'd1,
        ST_REFRESH  = 2'd2,
        ST_READY    = 2'd3
    } init_state_e;

    localparam int CKE_BIT   = 7;
    localparam int CS_N_BIT  = 6;
    localparam int CAS_N_BIT = 5;
    localparam int RAS_N_BIT = 4;
    localparam int WE_N_BIT  = 3;
    localparam int DQM_HI    = 1;
    localparam int DQM_LO    = 0;

    // Address line that selects "all banks" on PRECHARGE.
    localparam int A10_BIT = 10;

    localparam int PC133_INIT_DELAY   = 13334;
    localparam int PC133_T_RP         = 2;
    localparam int PC133_T_RC         = 8;
    localparam int PC133_T_MRD        = 2;
    localparam int PC133_NUM_INIT_REF = 8;

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational SDRAM command decoder.
//   command_bus : in  8  {cke, cs_n, cas_n, ras_n, we_n, rsvd, dqm[1:0]}
//   cmd         : out    decoded command; NOP for deselect and for cke=0 cycles
//   cke_err     : out 1  cke is low this cycle
// Only cs_n/ras_n/cas_n/we_n take part in the decode; dqm is ignored.
module sdram_cmd_decode
    import sdram_pkg::*;
(
    input  logic [7:0] command_bus,
    output cmd_e       cmd,
    output logic       cke_err
);

    logic [2:0] rcw;
    logic       unused_dqm;

    // dqm and the reserved bit carry no command information.
    assign unused_dqm = ^command_bus[2:0];

    always_comb begin
        rcw     = {command_bus[RAS_N_BIT], command_bus[CAS_N_BIT], command_bus[WE_N_BIT]};
        cke_err = ~command_bus[CKE_BIT];
        cmd     = NOP;
        // A cke=0 cycle is flagged but not decoded.
        if (!cke_err && !command_bus[CS_N_BIT]) begin
            case (rcw)
                3'b011:  cmd = ACT;
                3'b101:  cmd = RD;
                3'b100:  cmd = WR;
                3'b010:  cmd = PRE;
                3'b001:  cmd = REF;
                3'b000:  cmd = LMR;
                3'b110:  cmd = BST;
                default: cmd = NOP;
            endcase
        end
    end

endmodule

// File: rtl/sdram_cmd_checker.sv
// Device-side monitor for a PC133 SDRAM command interface. Decodes the pins every
// sdr_clk, follows the JEDEC power-up sequence (wait, precharge-all, auto-refreshes,
// load mode register) and checks PRE/REF/LMR busy windows.
//   sdr_clk, sdr_rst_n : clock (posedge) and async active-low reset
//   address_bus        : in  {addr[ADDR_BITS-1:0], bank[BA_BITS-1:0]}
//   command_bus        : in  {cke, cs_n, cas_n, ras_n, we_n, rsvd, dqm[1:0]}
//   cmd_valid/cmd_code : 1-cycle pulse + code for each non-NOP command
//   init_done          : power-up sequence completed legally
//   mode_reg/mode_valid: opcode of the last bank-0 LMR
//   ref_count          : auto-refreshes seen, saturating at 255
//   err_init/err_timing/err_illegal : sticky violation flags
// Optional build macro SDRAM_BANK_TRACK_EN adds bank_open[] and err_bank for
// per-bank open/closed tracking.
// All outputs are registered: one cycle from command edge to flag/pulse.
module sdram_cmd_checker
    import sdram_pkg::*;
#(
    parameter int ADDR_BITS    = 13,
    parameter int BA_BITS      = 2,
    parameter int INIT_DELAY   = PC133_INIT_DELAY,
    parameter int T_RP         = PC133_T_RP,
    parameter int T_RC         = PC133_T_RC,
    parameter int T_MRD        = PC133_T_MRD,
    parameter int NUM_INIT_REF = PC133_NUM_INIT_REF
) (
    input  logic                         sdr_clk,
    input  logic                         sdr_rst_n,
    input  logic [ADDR_BITS+BA_BITS-1:0] address_bus,
    input  logic [7:0]                   command_bus,
    output logic                         cmd_valid,
    output logic [2:0]                   cmd_code,
    output logic                         init_done,
    output logic [ADDR_BITS-1:0]         mode_reg,
    output logic                         mode_valid,
    output logic [7:0]                   ref_count,
    output logic                         err_init,
    output logic                         err_timing,
`ifdef SDRAM_BANK_TRACK_EN
    output logic [2**BA_BITS-1:0]        bank_open,
    output logic                         err_bank,
`endif
    output logic                         err_illegal
);

    localparam int PU_W  = (INIT_DELAY > 0) ? $clog2(INIT_DELAY + 1) : 1;
    localparam logic [PU_W-1:0] PU_MAX  = PU_W'(INIT_DELAY);
    // Last NOP cycle of the power-up wait; the FSM leaves POWERUP after it.
    localparam logic [PU_W-1:0] PU_LAST = (INIT_DELAY > 0) ? PU_W'(INIT_DELAY - 1) : '0;

    localparam int T_A     = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int T_MAX   = (T_RC > T_A) ? T_RC : T_A;
    localparam int BUSY_W  = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

    // ---- stage p0: combinational decode of the pins ----
    cmd_e                 cmd_p0;
    logic                 cke_err_p0;
    logic                 vld_p0;
    logic [ADDR_BITS-1:0] addr_p0;
    logic [BA_BITS-1:0]   bank_p0;
    logic                 a10_p0;

    sdram_cmd_decode u_decode (
        .command_bus (command_bus),
        .cmd         (cmd_p0),
        .cke_err     (cke_err_p0)
    );

    assign vld_p0  = (cmd_p0 != NOP);
    assign addr_p0 = address_bus[ADDR_BITS+BA_BITS-1:BA_BITS];
    assign bank_p0 = address_bus[BA_BITS-1:0];
    assign a10_p0  = addr_p0[A10_BIT];

    init_state_e        state;
    init_state_e        state_nxt;
    logic               init_viol_p0;
    logic               init_ok_p0;
    logic [PU_W-1:0]    pu_cnt;
    logic [7:0]         init_ref_cnt;
    logic [BUSY_W-1:0]  busy_cnt;

    always_ff @(posedge sdr_clk or negedge sdr_rst_n) begin
        if (!sdr_rst_n) begin
            state <= ST_POWERUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_viol_p0 = 1'b0;
        init_ok_p0   = 1'b0;
        case (state)
            ST_POWERUP: begin
                // Early commands are flagged but do not stop the wait counter.
                if (vld_p0) init_viol_p0 = 1'b1;
                if (pu_cnt >= PU_LAST) state_nxt = ST_WAIT_PRE;
            end
            ST_WAIT_PRE: begin
                if (cmd_p0 == PRE && a10_p0) state_nxt = ST_REFRESH;
                else if (vld_p0) init_viol_p0 = 1'b1;
            end
            ST_REFRESH: begin
                case (cmd_p0)
                    LMR: begin
                        if (init_ref_cnt >= 8'(NUM_INIT_REF)) begin
                            state_nxt  = ST_READY;
                            init_ok_p0 = 1'b1;
                        end else begin
                            init_viol_p0 = 1'b1;
                        end
                    end
                    ACT, RD, WR, PRE: init_viol_p0 = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // ---- stage p1: registered counters, flags and outputs ----
    always_ff @(posedge sdr_clk or negedge sdr_rst_n) begin
        if (!sdr_rst_n) begin
            cmd_valid    <= 1'b0;
            cmd_code     <= 3'd0;
            init_done    <= 1'b0;
            mode_reg     <= '0;
            mode_valid   <= 1'b0;
            ref_count    <= 8'd0;
            err_init     <= 1'b0;
            err_timing   <= 1'b0;
            err_illegal  <= 1'b0;
            pu_cnt       <= '0;
            init_ref_cnt <= 8'd0;
            busy_cnt     <= '0;
        end else begin
            cmd_valid <= vld_p0;
            cmd_code  <= cmd_p0;

            if (pu_cnt != PU_MAX) pu_cnt <= pu_cnt + 1'b1;

            if (cmd_p0 == REF && ref_count != 8'hFF) ref_count <= ref_count + 8'd1;
            if (cmd_p0 == REF && state == ST_REFRESH && init_ref_cnt != 8'hFF)
                init_ref_cnt <= init_ref_cnt + 8'd1;

            // A command issued inside the window is still honoured and reloads it.
            case (cmd_p0)
                PRE:     busy_cnt <= BUSY_W'(T_RP);
                REF:     busy_cnt <= BUSY_W'(T_RC);
                LMR:     busy_cnt <= BUSY_W'(T_MRD);
                default: if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
            endcase

            if (vld_p0 && busy_cnt != '0)       err_timing  <= 1'b1;
            if (init_viol_p0)                   err_init    <= 1'b1;
            if (init_ok_p0)                     init_done   <= 1'b1;
            if (cke_err_p0 || cmd_p0 == BST)    err_illegal <= 1'b1;

            if (cmd_p0 == LMR && bank_p0 == '0) begin
                mode_reg   <= addr_p0;
                mode_valid <= 1'b1;
            end
        end
    end

`ifdef SDRAM_BANK_TRACK_EN
    always_ff @(posedge sdr_clk or negedge sdr_rst_n) begin
        if (!sdr_rst_n) begin
            bank_open <= '0;
            err_bank  <= 1'b0;
        end else begin
            case (cmd_p0)
                ACT: begin
                    if (bank_open[bank_p0]) err_bank <= 1'b1;
                    bank_open[bank_p0] <= 1'b1;
                end
                RD, WR: begin
                    if (!bank_open[bank_p0]) err_bank <= 1'b1;
                end
                PRE: begin
                    if (a10_p0) bank_open <= '0;
                    else        bank_open[bank_p0] <= 1'b0;
                end
                REF, LMR: begin
                    if (|bank_open) err_bank <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule
